// File: rtl/thumb_bus_pkg.sv
// thumb_bus_pkg: state encoding and bus widths shared by the thumb memory arbiter
package thumb_bus_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/thumb_rr_pick.sv
// thumb_rr_pick: 2-way grant selection, round-robin on rr_last or fixed M1 priority
module thumb_rr_pick #(
   parameter bit FIXED = 1'b0
) (
   input  logic req0,
   input  logic req1,
   input  logic rr_last,
   output logic grant
);
   always_comb grant = (req0 & req1) ? (FIXED | ~rr_last) : req1;
endmodule

// File: rtl/thumb_mem_arbiter.sv
// thumb_mem_arbiter: shares one memory port between core (M0) and debug/loader (M1)
// masters, releasing a stuck transaction with an error after TIMEOUT wait cycles.
module thumb_mem_arbiter
   import thumb_bus_pkg::*;
#(
   parameter int TIMEOUT       = 255,
   parameter int M1_FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_valid,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   output logic              m0_ready,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic              m1_ready,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_valid,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   input  logic              s_ready,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              busy,
   output logic              owner
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t            state, nxt_state;
   logic              nxt_owner, rr_last, nxt_rr, pick, own_valid, tmo, rdy;
   logic [CW-1:0]     cnt, nxt_cnt;
   logic [DATA_W-1:0] rdata;

   thumb_rr_pick #(.FIXED(M1_FIXED_PRIO != 0)) u_pick (
      .req0    (m0_valid),
      .req1    (m1_valid),
      .rr_last (rr_last),
      .grant   (pick)
   );

   // rr_last resets to 1 so M0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= 1'b0;
         rr_last <= 1'b1;
         cnt     <= '0;
      end else begin
         state   <= nxt_state;
         owner   <= nxt_owner;
         rr_last <= nxt_rr;
         cnt     <= nxt_cnt;
      end
   end

   always_comb begin
      own_valid = owner ? m1_valid : m0_valid;
      tmo       = (state == BUSY) && own_valid && !s_ready && (cnt == CW'(TIMEOUT));
      nxt_state = state;
      nxt_owner = owner;
      nxt_rr    = rr_last;
      nxt_cnt   = cnt;
      s_valid   = 1'b0;
      s_we      = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_wstrb   = '0;
      rdy       = 1'b0;
      rdata     = '0;
      if (state == IDLE) begin
         if (m0_valid | m1_valid) begin
            nxt_state = BUSY;
            nxt_owner = pick;
         end
      end else begin
         s_valid = own_valid & ~tmo;
         s_we    = owner ? m1_we    : m0_we;
         s_addr  = owner ? m1_addr  : m0_addr;
         s_wdata = owner ? m1_wdata : m0_wdata;
         s_wstrb = owner ? m1_wstrb : m0_wstrb;
         rdy     = s_ready | tmo;
         rdata   = tmo ? '0 : s_rdata;
         // an abandoned request leaves the round-robin history untouched
         if (!own_valid || s_ready || tmo) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            if (own_valid) nxt_rr = owner;
         end else begin
            nxt_cnt = cnt + 1'b1;
         end
      end
      m0_ready = rdy & ~owner;
      m1_ready = rdy & owner;
      m0_err   = tmo & ~owner;
      m1_err   = tmo & owner;
      m0_rdata = owner ? '0 : rdata;
      m1_rdata = owner ? rdata : '0;
   end

   assign busy = (state == BUSY);
endmodule

// File: tb/tb_thumb_mem_arbiter.sv
// tb_thumb_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration and timeout rules.
module tb_thumb_mem_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0, rst_n;
   logic        m0_valid, m0_we, m1_valid, m1_we, s_ready;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m0_err, m1_ready, m1_err, s_valid, s_we, busy, owner;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err, fp_s_valid, fp_s_we, fp_busy, fp_owner;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_wstrb;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   thumb_mem_arbiter #(.TIMEOUT(TO), .M1_FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata), .busy(busy), .owner(owner)
   );

   thumb_mem_arbiter #(.TIMEOUT(TO), .M1_FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(fp_m0_ready), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
      .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(fp_m1_ready), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
      .s_valid(fp_s_valid), .s_we(fp_s_we), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata), .busy(fp_busy), .owner(fp_owner)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_ready = 0; s_rdata = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      step();
   endtask

   task automatic test_reset;
      clear_inputs();
      m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'hffff_ffff;
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b exp 0", s_valid); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b exp 0", owner); end
      checks++; if ({m0_ready, m1_ready, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_ready_err: got %b exp 0000", {m0_ready, m1_ready, m0_err, m1_err}); end
      checks++; if ({s_addr, m0_rdata, m1_rdata} !== 96'b0) begin errors++; $display("FAIL reset_data: got %h exp 0", {s_addr, m0_rdata, m1_rdata}); end
   endtask

   task automatic test_m0_read;
      int sv = 0;
      do_reset();
      m0_valid = 1; m0_addr = 32'h10;
      for (int i = 0; i < 4; i++) begin
         s_ready = (i == 3);
         s_rdata = (i == 3) ? 32'h1234_5678 : 32'hdead_beef;
         @(negedge clk);
         sv += int'(s_valid);
         checks++; if (busy !== (i != 0)) begin errors++; $display("FAIL read_busy%0d: got %b exp %b", i, busy, i != 0); end
         checks++; if (m0_ready !== (i == 3)) begin errors++; $display("FAIL read_ready%0d: got %b exp %b", i, m0_ready, i == 3); end
         if (i == 3) begin
            checks++; if (m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata: got %h exp 12345678", m0_rdata); end
            checks++; if (s_addr !== 32'h10) begin errors++; $display("FAIL read_addr: got %h exp 10", s_addr); end
         end
         step();
      end
      m0_valid = 0; s_ready = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_after_busy: got %b exp 0", busy); end
      checks++; if (sv != 3) begin errors++; $display("FAIL read_svalid_cycles: got %0d exp 3", sv); end
      step();
   endtask

   task automatic test_tie_rr;
      logic eo;
      do_reset();
      m0_valid = 1; m0_addr = 32'h100; m1_valid = 1; m1_addr = 32'h200; s_ready = 1; s_rdata = 32'h55;
      for (int i = 0; i < 6; i++) begin
         eo = (i == 3);
         @(negedge clk);
         checks++; if (busy !== i[0]) begin errors++; $display("FAIL tie_busy%0d: got %b exp %b", i, busy, i[0]); end
         if (i[0]) begin
            checks++; if (owner !== eo) begin errors++; $display("FAIL tie_owner%0d: got %b exp %b", i, owner, eo); end
            checks++; if (s_addr !== (eo ? 32'h200 : 32'h100)) begin errors++; $display("FAIL tie_addr%0d: got %h", i, s_addr); end
            checks++; if ({m1_ready, m0_ready} !== (eo ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_ready%0d: got %b exp %b", i, {m1_ready, m0_ready}, eo ? 2'b10 : 2'b01); end
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_fixed_prio;
      int grants = 0;
      do_reset();
      m0_valid = 1; m0_addr = 32'h300; m1_valid = 1; m1_addr = 32'h400; s_ready = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fp_busy) begin
            grants++;
            checks++; if (fp_owner !== 1'b1) begin errors++; $display("FAIL fp_owner%0d: got %b exp 1", i, fp_owner); end
         end
         checks++; if (fp_m0_ready !== 1'b0) begin errors++; $display("FAIL fp_m0_ready%0d: got %b exp 0", i, fp_m0_ready); end
         step();
      end
      checks++; if (grants != 5) begin errors++; $display("FAIL fp_grants: got %0d exp 5", grants); end
      clear_inputs();
   endtask

   task automatic test_timeout;
      do_reset();
      m1_valid = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'ha5a5_5a5a; m1_wstrb = 4'hf; s_rdata = 32'h1111_2222;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b exp 0", busy); end
      step();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy%0d: got %b exp 1", k, busy); end
         checks++; if (s_valid !== (k < 5)) begin errors++; $display("FAIL to_svalid%0d: got %b exp %b", k, s_valid, k < 5); end
         checks++; if ({m1_ready, m1_err} !== ((k == 5) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL to_ready_err%0d: got %b", k, {m1_ready, m1_err}); end
         if (k < 5) begin
            checks++; if ({s_we, s_wdata, s_wstrb} !== {1'b1, 32'ha5a5_5a5a, 4'hf}) begin errors++; $display("FAIL to_write%0d: got %b %h %h", k, s_we, s_wdata, s_wstrb); end
         end else begin
            checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", m1_rdata); end
         end
         step();
      end
      m1_valid = 0;
      @(negedge clk);
      checks++; if ({busy, s_valid, m1_err} !== 3'b0) begin errors++; $display("FAIL to_after: got %b exp 000", {busy, s_valid, m1_err}); end
      step();
      clear_inputs();
   endtask

   task automatic test_timeout_ready;
      do_reset();
      m0_valid = 1; m0_addr = 32'h44; s_rdata = 32'h0bad_0bad;
      step();
      for (int k = 1; k <= 5; k++) begin
         s_ready = (k == 5);
         s_rdata = (k == 5) ? 32'hcafe_f00d : 32'h0bad_0bad;
         @(negedge clk);
         checks++; if ({m0_ready, m0_err} !== ((k == 5) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL tr_ready_err%0d: got %b", k, {m0_ready, m0_err}); end
         if (k == 5) begin
            checks++; if (m0_rdata !== 32'hcafe_f00d) begin errors++; $display("FAIL tr_rdata: got %h exp cafef00d", m0_rdata); end
            checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL tr_svalid: got %b exp 1", s_valid); end
         end
         step();
      end
      m0_valid = 0; s_ready = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tr_after: got %b exp 0", busy); end
      step();
   endtask

   task automatic test_reset_mid_busy;
      do_reset();
      m0_valid = 1; m0_addr = 32'h80; s_ready = 1; s_rdata = 32'h77;
      step();
      step();
      s_ready = 0;
      step();
      @(negedge clk);
      checks++; if ({busy, s_valid} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre: got %b exp 11", {busy, s_valid}); end
      #2 rst_n = 0;
      #1;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_svalid: got %b exp 0", s_valid); end
      checks++; if ({busy, owner} !== 2'b00) begin errors++; $display("FAIL rst_mid_state: got %b exp 00", {busy, owner}); end
      m1_valid = 1; m1_addr = 32'h90; s_ready = 1;
      @(posedge clk);
      @(negedge clk) rst_n = 1;
      step();
      @(negedge clk);
      checks++; if ({busy, owner} !== 2'b10) begin errors++; $display("FAIL rst_mid_tie: got %b exp 10", {busy, owner}); end
      step();
      clear_inputs();
   endtask

   task automatic test_valid_drop;
      do_reset();
      m0_valid = 1; m0_addr = 32'hc0;
      step();
      @(negedge clk);
      checks++; if ({busy, s_valid} !== 2'b11) begin errors++; $display("FAIL drop_pre: got %b exp 11", {busy, s_valid}); end
      step();
      m0_valid = 0;
      @(negedge clk);
      checks++; if ({s_valid, m0_ready, m0_err} !== 3'b0) begin errors++; $display("FAIL drop_cycle: got %b exp 000", {s_valid, m0_ready, m0_err}); end
      step();
      m0_valid = 1; m1_valid = 1; m1_addr = 32'hd0; s_ready = 1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b exp 0", busy); end
      step();
      @(negedge clk);
      checks++; if ({busy, owner} !== 2'b10) begin errors++; $display("FAIL drop_rr_kept: got %b exp 10", {busy, owner}); end
      step();
      clear_inputs();
   endtask

   // reference: each master holds its request until served; model tracks the grant,
   // round-robin history and consecutive wait cycles of the active transaction
   task automatic test_random;
      bit mb = 0, mo = 0, ml = 1, p0 = 0, p1 = 0, ov, to, er;
      int mw = 0;
      logic [31:0] ea, ed;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         if (!p0 && $urandom_range(0, 2) == 0) begin
            p0 = 1; m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
         end
         if (!p1 && $urandom_range(0, 2) == 0) begin
            p1 = 1; m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
         end
         m0_valid = p0; m1_valid = p1;
         s_ready = ($urandom_range(0, 3) == 0);
         s_rdata = $urandom;
         @(negedge clk);
         if (!mb) begin
            checks++; if ({busy, s_valid, m0_ready, m1_ready} !== 4'b0) begin errors++; $display("FAIL rnd_idle c%0d: got %b exp 0000", c, {busy, s_valid, m0_ready, m1_ready}); end
            if (p0 || p1) begin mb = 1; mo = (p0 && p1) ? !ml : p1; mw = 0; end
         end else begin
            ov = mo ? p1 : p0;
            to = ov && !s_ready && mw == TO;
            er = s_ready || to;
            ea = mo ? m1_addr : m0_addr;
            ed = to ? 32'h0 : s_rdata;
            checks++; if ({busy, owner} !== {1'b1, mo}) begin errors++; $display("FAIL rnd_owner c%0d: got %b exp %b", c, {busy, owner}, {1'b1, mo}); end
            checks++; if (s_valid !== (ov && !to)) begin errors++; $display("FAIL rnd_svalid c%0d: got %b exp %b", c, s_valid, ov && !to); end
            checks++; if (s_addr !== ea) begin errors++; $display("FAIL rnd_addr c%0d: got %h exp %h", c, s_addr, ea); end
            checks++; if ({m1_ready, m0_ready} !== {er && mo, er && !mo}) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, {m1_ready, m0_ready}, {er && mo, er && !mo}); end
            checks++; if ({m1_err, m0_err} !== {to && mo, to && !mo}) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", c, {m1_err, m0_err}, {to && mo, to && !mo}); end
            checks++; if ((mo ? m1_rdata : m0_rdata) !== ed) begin errors++; $display("FAIL rnd_rdata c%0d: got %h exp %h", c, mo ? m1_rdata : m0_rdata, ed); end
            checks++; if ((mo ? m0_rdata : m1_rdata) !== 32'h0) begin errors++; $display("FAIL rnd_other_rdata c%0d: got %h exp 0", c, mo ? m0_rdata : m1_rdata); end
            if (ov && er) begin
               if (mo) p1 = 0; else p0 = 0;
            end
            if (!ov || s_ready || to) begin
               mb = 0;
               if (ov) ml = mo;
            end else begin
               mw++;
            end
         end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1;
      #2;
      test_reset();
      test_m0_read();
      test_tie_rr();
      test_fixed_prio();
      test_timeout();
      test_timeout_ready();
      test_reset_mid_busy();
      test_valid_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/thumb_mem_arbiter.md
THUMB_MEM_ARBITER -- requirements
Module: thumb_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles without s_ready before the error release.
REQ-002 SHALL have parameter M1_FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 makes M1 always win ties.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_valid/m0_we  input  1 each  core request valid and write-enable.
REQ-006 SHALL have ports m0_addr/m0_wdata  input  32 each, and m0_wstrb  input  4: core byte address, write data and byte strobes.
REQ-007 SHALL have ports m0_ready/m0_err  output  1 each, and m0_rdata  output  32: core completion, error flag and read data.
REQ-008 SHALL have ports m1_valid, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_err, m1_rdata, identical to the m0 ports, for the debug/loader master.
REQ-009 SHALL have ports s_valid, s_we  output  1; s_addr, s_wdata  output  32; s_wstrb  output  4: the shared memory request.
REQ-010 SHALL have ports s_ready  input  1 and s_rdata  input  32: the memory response.
REQ-011 SHALL have ports busy  output  1 (arbiter in BUSY) and owner  output  1 (granted master, 0=M0, 1=M1).

Function
REQ-012 SHALL implement the state machine IDLE -> BUSY -> IDLE, holding the registers state, owner, rr_last (last completed master) and a timeout counter of width clog2(TIMEOUT+1).
REQ-013 In IDLE, s_valid, m0_ready, m1_ready, m0_err and m1_err SHALL be 0; if any mX_valid=1, the arbiter SHALL latch owner and enter BUSY next cycle, so arbitration latency is 1 cycle.
REQ-014 SHALL grant the sole requester when only one master is valid.
REQ-015 When both masters are valid, the grant SHALL go to M1 if M1_FIXED_PRIO=1, else to !rr_last.
REQ-016 In BUSY, s_valid/s_we/s_addr/s_wdata/s_wstrb SHALL combinationally equal the owner's request signals, and the owner's mX_rdata SHALL equal s_rdata.
REQ-017 In BUSY, the owner's mX_ready SHALL equal s_ready; the non-owner's ready and err SHALL be 0 and its rdata SHALL be 0.
REQ-018 Completion (BUSY and s_valid and s_ready) SHALL return to IDLE, set rr_last=owner and clear the counter; back-to-back transactions therefore cost 1 idle cycle each.
REQ-019 If the owner drops valid while in BUSY before s_ready, the arbiter SHALL return to IDLE next cycle with no completion and SHALL leave rr_last unchanged.
REQ-020 The counter SHALL increment on every BUSY cycle without s_ready; when it equals TIMEOUT, s_valid SHALL be 0 for that cycle, and owner mX_ready=1, mX_err=1, mX_rdata=0 SHALL be driven for exactly that cycle, followed by IDLE and rr_last=owner.
REQ-021 If s_ready and the timeout coincide, the arbiter SHALL treat the cycle as a normal completion with err=0.
REQ-022 mX_err SHALL be 1 only in the timeout cycle.
REQ-023 The non-owner's requests SHALL be ignored until IDLE; a request held across a grant to the other master SHALL be served next, with no loss of the request.
REQ-024 A write that times out SHALL be considered not performed; no retry SHALL be issued.

Reset
REQ-025 While rst_n=0 (asynchronous): state=IDLE, owner=0, rr_last=1 so M0 wins the first tie, counter=0; all outputs 0.
REQ-026 Reset in mid-BUSY SHALL abort the transaction immediately, and s_valid SHALL drop without waiting for a clock edge.

Structure
REQ-027 A shared package thumb_bus_pkg SHALL hold the state encodings (IDLE=0, BUSY=1) and the bus width constants ADDR_W=32, DATA_W=32, STRB_W=4.
REQ-028 One sub-module, thumb_rr_pick (2-way round-robin/fixed-priority grant selection, purely combinational), SHALL be used; the request muxing stays in the top module.

Verification
REQ-029 Bench SHALL cover: M0 read only, addr 0x10, memory ready after 2 wait cycles, rdata 0x12345678 -> s_valid high 3 cycles; m0_ready pulse 1 cycle with m0_rdata=0x12345678; busy=0 next cycle.
REQ-030 Bench SHALL cover: M0 and M1 valid on the same cycle after reset, M1_FIXED_PRIO=0 -> M0 served first, then M1 after 1 IDLE cycle; on the next tie M1 wins.
REQ-031 Bench SHALL cover: M1_FIXED_PRIO=1, both masters continuously requesting -> every grant goes to M1 and m0_ready never asserts (documented starvation).
REQ-032 Bench SHALL cover: TIMEOUT=4, memory never ready, M1 write -> m1_ready=m1_err=1 on the 5th BUSY cycle (counter=4), s_valid=0 that cycle, IDLE after.
REQ-033 Bench SHALL cover: s_ready arriving exactly on the timeout cycle -> err=0 and normal completion data is delivered.
REQ-034 Bench SHALL cover: rst_n low mid-BUSY (M0 owner), and separately M0 dropping valid mid-BUSY -> reset: s_valid=0 asynchronously, owner=0, rr_last=1; valid drop: return to IDLE and rr_last unchanged.
